// File: rtl/fir_seq_pkg.sv
// Purpose: shared types and constants for the FIR multiply-accumulate sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_seq_pkg;

    // Arithmetic interpretation of samples/coefficients. Encodings 2 and 3 both
    // select fixed point.
    typedef enum logic [1:0] {
        MODE_UNSIGNED = 2'd0,
        MODE_SIGNED   = 2'd1,
        MODE_FIXED    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    localparam logic [3:0] FN_MUL = 4'd0;

    // Tap index width; never below 1 so a single-tap build still has a real port.
    function automatic int addr_w(input int max_order);
        return (max_order > 1) ? $clog2(max_order) : 1;
    endfunction

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_UNSIGNED;
            2'd1:    return MODE_SIGNED;
            default: return MODE_FIXED;
        endcase
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Purpose: circular sample buffer; write at wp then wp+1, read newest-first by tap offset.
// Latency: write visible on the read port the cycle after wr_en_i; read is combinational.
// Backpressure: none; the caller only writes on sample accept.
// Ports: clock/reset (sync, active-high, clears wp only), wr_en_i/wr_data_i write port,
//        rd_ofs_i tap offset j, rd_data_o = x[wp-1-j].
module fir_delay_line
    import fir_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic [ADDR_W-1:0] rd_ofs_i,
    output logic [XLEN-1:0]   rd_data_o
);

    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W-1:0] wp_d;
    logic [ADDR_W-1:0] rd_idx;

    // DEPTH is a power of two, so natural ADDR_W wrap gives the modulo.
    assign wp_d   = wr_en_i ? (wp_q + {{(ADDR_W-1){1'b0}}, 1'b1}) : wp_q;
    assign rd_idx = wp_q - {{(ADDR_W-1){1'b0}}, 1'b1} - rd_ofs_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_d;
        end
    end

    // Sample storage is deliberately not cleared; the sample count in the
    // sequencer guarantees stale entries are never read.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wp_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Purpose: streaming FIR; one multiply per tap through a shared req/resp multiplier, one output per input.
// Latency: sum over taps of (issue + req stall + multiplier latency + 1) + 1 cycles from accept to out_valid.
// Backpressure: in_ready only in IDLE; requests held until mul_req_ready; output held until out_ready.
// Ports: cfg_* sampled at sample accept; coef_wr_* write the coefficient RAM (IDLE only);
//        in_* sample stream; mul_* multiplier interface; out_* result stream; tag_err sticky; busy = not IDLE.
// Optional: define FIR_MAC_SAT_EN to saturate out_data (and flag out_sat) instead of truncating.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_ORDER = 256,
    parameter int ACC_W     = 64,
    parameter int TAG_W     = 5,
    localparam int ADDR_W   = addr_w(MAX_ORDER)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W:0]   cfg_order,
    input  logic [1:0]        cfg_mode,
    input  logic [5:0]        cfg_binary_point,
    input  logic              coef_wr_en,
    input  logic [ADDR_W-1:0] coef_wr_addr,
    input  logic [XLEN-1:0]   coef_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_data,
    output logic              mul_req_valid,
    input  logic              mul_req_ready,
    output logic [3:0]        mul_req_fn,
    output logic              mul_req_dw,
    output logic [TAG_W-1:0]  mul_req_tag,
    output logic [XLEN-1:0]   mul_rs1,
    output logic [XLEN-1:0]   mul_rs2,
    output logic              mul_kill,
    input  logic              mul_resp_valid,
    output logic              mul_resp_ready,
    input  logic [XLEN-1:0]   mul_resp_data,
    input  logic [TAG_W-1:0]  mul_resp_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_sat,
    output logic              tag_err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_ORDER);
    localparam logic [ADDR_W:0]   ONE_CNT = (ADDR_W+1)'(1);
    localparam logic [ADDR_W+1:0] ONE_P1  = (ADDR_W+2)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   taps_q,  taps_d;
    logic [ADDR_W:0]   j_q,     j_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    mode_e             mode_q,  mode_d;
    logic [5:0]        bp_q,    bp_d;
    logic              tag_err_q, tag_err_d;

    logic [XLEN-1:0]   coef_mem [MAX_ORDER];
    logic [XLEN-1:0]   dl_rd_dat;
    logic              accept;
    logic [ADDR_W:0]   order_eff;
    logic [ADDR_W+1:0] cnt_p1;
    logic [ADDR_W:0]   taps_new;
    logic [ADDR_W:0]   j_inc;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  prod_term;
    logic [XLEN-1:0]   res_dat;
    logic              res_sat;

    assign accept = (state_q == IDLE) && in_valid;

    // ------------------------------------------------------------------
    // Coefficient RAM: writes outside IDLE are dropped. A write in the
    // accept cycle lands before the first request is issued, so it is
    // seen by that sample.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (coef_wr_en && (state_q == IDLE)) begin
            coef_mem[coef_wr_addr] <= coef_wr_data;
        end
    end

    fir_delay_line #(
        .XLEN  (XLEN),
        .DEPTH (MAX_ORDER)
    ) u_dl (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .rd_ofs_i  (j_q[ADDR_W-1:0]),
        .rd_data_o (dl_rd_dat)
    );

    // ------------------------------------------------------------------
    // Tap count for a new sample: order 0 behaves as 1, oversize orders
    // clamp to the RAM depth, and early samples only use the history
    // that exists (count+1 entries).
    // ------------------------------------------------------------------
    always_comb begin
        order_eff = cfg_order;
        if (cfg_order == '0) begin
            order_eff = ONE_CNT;
        end else if (cfg_order > MAX_CNT) begin
            order_eff = MAX_CNT;
        end
        cnt_p1   = {1'b0, count_q} + ONE_P1;
        taps_new = (cnt_p1 < {1'b0, order_eff}) ? cnt_p1[ADDR_W:0] : order_eff;
    end

    assign j_inc = j_q + ONE_CNT;

    // Product extension and fixed-point scaling. The multiplier returns only
    // the low XLEN bits, so signed modes sign-extend from bit XLEN-1.
    always_comb begin
        if (mode_q == MODE_UNSIGNED) begin
            prod_ext = ACC_W'(mul_resp_data);
        end else begin
            prod_ext = ACC_W'($signed(mul_resp_data));
        end
        if (mode_q == MODE_FIXED) begin
            prod_term = $signed(prod_ext) >>> bp_q;
        end else begin
            prod_term = prod_ext;
        end
    end

    // ------------------------------------------------------------------
    // Output formatting
    // ------------------------------------------------------------------
`ifdef FIR_MAC_SAT_EN
    localparam logic [ACC_W-1:0] UMAX = ACC_W'({XLEN{1'b1}});
    localparam logic [ACC_W-1:0] SMAX = ACC_W'({1'b0, {(XLEN-1){1'b1}}});
    localparam logic [ACC_W-1:0] SMIN = ~SMAX;

    always_comb begin
        res_dat = acc_q[XLEN-1:0];
        res_sat = 1'b0;
        if (mode_q == MODE_UNSIGNED) begin
            if (acc_q > UMAX) begin
                res_dat = {XLEN{1'b1}};
                res_sat = 1'b1;
            end
        end else begin
            if ($signed(acc_q) > $signed(SMAX)) begin
                res_dat = SMAX[XLEN-1:0];
                res_sat = 1'b1;
            end else if ($signed(acc_q) < $signed(SMIN)) begin
                res_dat = SMIN[XLEN-1:0];
                res_sat = 1'b1;
            end
        end
    end
`else
    always_comb begin
        res_dat = acc_q[XLEN-1:0];
        res_sat = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            taps_q    <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            mode_q    <= MODE_UNSIGNED;
            bp_q      <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            taps_q    <= taps_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            bp_q      <= bp_d;
            tag_err_q <= tag_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        taps_d    = taps_q;
        j_d       = j_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        bp_d      = bp_q;
        tag_err_d = tag_err_q;

        // A response the sequencer is not waiting for means the multiplier
        // and sequencer disagree about what is outstanding.
        if (mul_resp_valid && (state_q != WAIT)) begin
            tag_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = decode_mode(cfg_mode);
                    bp_d    = cfg_binary_point;
                    taps_d  = taps_new;
                    count_d = (count_q == MAX_CNT) ? MAX_CNT : (count_q + ONE_CNT);
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mul_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mul_resp_valid) begin
                    acc_d = acc_q + prod_term;
                    if (mul_resp_tag != TAG_W'(j_q)) begin
                        tag_err_d = 1'b1;
                    end
                    j_d     = j_inc;
                    state_d = (j_inc == taps_q) ? OUTPUT : ISSUE;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Data buses are zeroed outside their valid state so
    // uninitialised RAM contents never leave the block.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready       = (state_q == IDLE);
        mul_req_valid  = (state_q == ISSUE);
        mul_req_fn     = FN_MUL;
        mul_req_dw     = 1'b0;
        mul_req_tag    = '0;
        mul_rs1        = '0;
        mul_rs2        = '0;
        mul_resp_ready = (state_q == WAIT);
        mul_kill       = reset && ((state_q == ISSUE) || (state_q == WAIT));
        out_valid      = (state_q == OUTPUT);
        out_data       = '0;
        out_sat        = 1'b0;
        tag_err        = tag_err_q;
        busy           = (state_q != IDLE);

        if (state_q == ISSUE) begin
            mul_req_tag = TAG_W'(j_q);
            mul_rs1     = coef_mem[j_q[ADDR_W-1:0]];
            mul_rs2     = dl_rd_dat;
        end
        if (state_q == OUTPUT) begin
            out_data = res_dat;
            out_sat  = res_sat;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  cfg_order;
    logic [1:0]  cfg_mode;
    logic [5:0]  cfg_binary_point;
    logic        coef_wr_en;
    logic [7:0]  coef_wr_addr;
    logic [31:0] coef_wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mul_req_valid;
    logic        mul_req_ready;
    logic [3:0]  mul_req_fn;
    logic        mul_req_dw;
    logic [4:0]  mul_req_tag;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic        mul_kill;
    logic        mul_resp_valid;
    logic        mul_resp_ready;
    logic [31:0] mul_resp_data;
    logic [4:0]  mul_resp_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        tag_err;
    logic        busy;

    always #5 clock = ~clock;

    fir_mac_sequencer dut (
        .clock(clock), .reset(reset),
        .cfg_order(cfg_order), .cfg_mode(cfg_mode), .cfg_binary_point(cfg_binary_point),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
        .mul_req_fn(mul_req_fn), .mul_req_dw(mul_req_dw), .mul_req_tag(mul_req_tag),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_kill(mul_kill),
        .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready),
        .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .tag_err(tag_err), .busy(busy)
    );

    // ---------------- multiplier model ----------------
    logic        stall_req = 1'b0;
    logic        spur = 1'b0;
    int          lat = 2;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_tag = '0;

    assign mul_req_ready  = !m_busy && !stall_req;
    assign mul_resp_valid = (m_busy && (m_cnt == 0)) || spur;
    assign mul_resp_data  = m_res;
    assign mul_resp_tag   = m_tag;

    always @(posedge clock) begin
        if (reset || mul_kill) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                if (mul_resp_ready) m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mul_req_valid && mul_req_ready) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_res  <= mul_rs1 * mul_rs2;
            m_tag  <= mul_req_tag;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%0h with no expected entry", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, e.d});
                chk("out_sat", {63'd0, out_sat}, {63'd0, e.s});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr_coef(input int a, input logic [31:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a[7:0];
        coef_wr_data = d;
        tick();
        coef_wr_en   = 1'b0;
    endtask

    task automatic start_sample(input logic [31:0] x);
        logic got;
        got      = 1'b0;
        in_data  = x;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {63'd0, got}, 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] e, input logic es);
        exp_t t;
        t.d = e;
        t.s = es;
        exp_q.push_back(t);
        start_sample(x);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && in_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {63'd0, done}, 64'd1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cfg_order = 9'd1;
        cfg_mode = 2'd0;
        cfg_binary_point = 6'd0;
        coef_wr_en = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        // reset state
        do_reset();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_valid", {63'd0, mul_req_valid}, 64'd0);
        chk("rst_tag_err", {63'd0, tag_err}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);

        // unsigned, order 3: 1,3,6,6
        cfg_mode = 2'd0; cfg_order = 9'd3;
        wr_coef(0, 32'd1); wr_coef(1, 32'd2); wr_coef(2, 32'd3);
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd3, 1'b0);
        send(32'd1, 32'd6, 1'b0);
        send(32'd1, 32'd6, 1'b0);
        drain();
        chk("uns_tag_err", {63'd0, tag_err}, 64'd0);

        // signed: coeffs {-1,2}, inputs 5,-3 -> -5, 13
        do_reset();
        cfg_mode = 2'd1; cfg_order = 9'd2;
        wr_coef(0, 32'hFFFF_FFFF); wr_coef(1, 32'd2);
        send(32'd5, 32'hFFFF_FFFB, 1'b0);
        send(32'hFFFF_FFFD, 32'd13, 1'b0);
        drain();

        // fixed point: 0x18 * 0x20 = 0x300, >>4 = 0x30
        do_reset();
        cfg_mode = 2'd2; cfg_order = 9'd1; cfg_binary_point = 6'd4;
        wr_coef(0, 32'h18);
        send(32'h20, 32'h30, 1'b0);
        drain();
        cfg_binary_point = 6'd0;

        // backpressure on request and output
        do_reset();
        cfg_mode = 2'd0; cfg_order = 9'd1;
        wr_coef(0, 32'd3);
        stall_req = 1'b1;
        out_ready = 1'b0;
        send(32'd9, 32'd27, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_req_valid", {63'd0, mul_req_valid}, 64'd1);
            chk("stall_rs1", {32'd0, mul_rs1}, 64'd3);
            chk("stall_rs2", {32'd0, mul_rs2}, 64'd9);
            chk("stall_tag", {59'd0, mul_req_tag}, 64'd0);
        end
        tick();
        wr_coef(0, 32'd100);  // busy: must be dropped
        stall_req = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("out_valid_timeout", {63'd0, seen}, 64'd1);
        end
        for (int k = 0; k < 10; k++) begin
            chk("hold_out_data", {32'd0, out_data}, 64'd27);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_req_valid", {63'd0, mul_req_valid}, 64'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        drain();
        // coefficient write during busy was dropped: 3*1 + history ignored (order 1)
        send(32'd1, 32'd3, 1'b0);
        drain();

        // reset while waiting on the multiplier
        do_reset();
        lat = 20;
        cfg_mode = 2'd0; cfg_order = 9'd1;
        wr_coef(0, 32'd4);
        start_sample(32'd5);
        begin
            logic inwait;
            inwait = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (mul_resp_ready) begin
                    inwait = 1'b1;
                    break;
                end
            end
            chk("reach_wait", {63'd0, inwait}, 64'd1);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("kill_in_wait", {63'd0, mul_kill}, 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        lat = 2;
        @(negedge clock);
        chk("busy_after_kill", {63'd0, busy}, 64'd0);
        tick();
        cfg_order = 9'd3;
        wr_coef(0, 32'd2);
        send(32'd7, 32'd14, 1'b0);
        drain();

        // saturation behaviour on signed overflow
        do_reset();
        cfg_mode = 2'd1; cfg_order = 9'd2;
        wr_coef(0, 32'h7FFF_FFFF); wr_coef(1, 32'h7FFF_FFFF);
        send(32'd1, 32'h7FFF_FFFF, 1'b0);
`ifdef FIR_MAC_SAT_EN
        send(32'd1, 32'h7FFF_FFFF, 1'b1);
`else
        send(32'd1, 32'hFFFF_FFFE, 1'b0);
`endif
        drain();

        // order 0 behaves as a single tap
        do_reset();
        cfg_mode = 2'd0; cfg_order = 9'd0;
        wr_coef(0, 32'd5); wr_coef(1, 32'd9);
        send(32'd4, 32'd20, 1'b0);
        send(32'd3, 32'd15, 1'b0);
        drain();

        // stray response while idle sets the sticky flag; reset clears it
        chk("pre_spur_tag_err", {63'd0, tag_err}, 64'd0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        @(negedge clock);
        chk("spur_tag_err", {63'd0, tag_err}, 64'd1);
        tick();
        chk("tag_err_sticky", {63'd0, tag_err}, 64'd1);
        do_reset();
        chk("tag_err_cleared", {63'd0, tag_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
